// File: rtl/fpu_addsub_param_if.sv
// Operand/result handshake bundle between the FPU issue stage, the adder and writeback.
interface fpu_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         sub;
    logic [1:0]   rnd_mode;
    logic [W-1:0] output_c;
    logic         out_valid;
    logic         out_ready;
    logic         flag_invalid;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_inexact;

    modport master (
        output in_valid, input_a, input_b, sub, rnd_mode, out_ready,
        input  in_ready, output_c, out_valid,
               flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );

    modport slave (
        input  in_valid, input_a, input_b, sub, rnd_mode, out_ready,
        output in_ready, output_c, out_valid,
               flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/fpu_addsub_param.sv
// Parametrised multi-cycle IEEE-754 adder/subtractor with valid/ready handshake.
// Define FPADD_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fpu_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    fpu_addsub_param_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;              // hidden + fraction + guard/round/sticky
    localparam int SH_W  = $clog2(SIG_W + 1);
    localparam int XE_W  = EXP_W + 2;              // headroom for carry and rounding increments

`ifdef FPADD_SUBNORMAL_EN
    localparam bit SUBNORM_EN = 1'b1;
`else
    localparam bit SUBNORM_EN = 1'b0;
`endif

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAX  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]     QNAN     = {1'b1, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_HOLD} state_t;
    typedef enum logic [1:0] {RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11} rnd_t;

    state_t r_state, w_next;

    logic             r_sign_a, r_sign_b, r_sub;
    logic [EXP_W-1:0] r_expf_a, r_expf_b;
    logic [SIG_W-1:0] r_sig_a, r_sig_b;
    rnd_t             r_rnd;
    logic [SIG_W-1:0] r_big, r_small, r_nsig;
    logic [XE_W-1:0]  r_exp;
    logic             r_sign, r_eff_sub, r_bypass, r_sp_inv, r_nzero;
    logic [W-1:0]     r_sp_res;
    logic [SIG_W:0]   r_sum;

    logic [W-1:0]     r_out_c;
    logic             r_out_valid, r_flag_inv, r_flag_ovf, r_flag_unf, r_flag_inx;

    function automatic logic [SIG_W-1:0] unpack_sig(input logic [W-1:0] x);
        logic             hidden;
        logic [MAN_W-1:0] frac;
        hidden = |x[W-2:MAN_W];
        frac   = x[MAN_W-1:0];
        if (!SUBNORM_EN && !hidden) frac = '0;
        return {hidden, frac, 3'b000};
    endfunction

    function automatic logic [XE_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? XE_W'(1) : {2'b00, e};
    endfunction

    function automatic logic [SH_W-1:0] lzc(input logic [SIG_W-1:0] x);
        logic [SH_W-1:0] n;
        logic            found;
        n     = SH_W'(SIG_W);
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                n     = SH_W'(SIG_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // NOTE: state register uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid) w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADDSUB;
            S_ADDSUB: w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_HOLD;
            S_HOLD:   if (bus.out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- ALIGN: classification, special cases, operand swap and shift
    logic             w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
    logic             w_sign_b, w_eff_sub, w_a_ge, w_sign_big, w_special, w_sp_inv, w_lost;
    logic [XE_W-1:0]  w_exp_a, w_exp_b, w_exp_big, w_diff;
    logic [SIG_W-1:0] w_big, w_small_raw, w_shifted, w_small_al;
    logic [SH_W-1:0]  w_shamt;
    logic [W-1:0]     w_sp_res;

    always_comb begin
        w_a_nan    = (&r_expf_a) && (|r_sig_a[SIG_W-2:3]);
        w_a_inf    = (&r_expf_a) && !(|r_sig_a[SIG_W-2:3]);
        w_a_zero   = (r_sig_a == '0);
        w_b_nan    = (&r_expf_b) && (|r_sig_b[SIG_W-2:3]);
        w_b_inf    = (&r_expf_b) && !(|r_sig_b[SIG_W-2:3]);
        w_b_zero   = (r_sig_b == '0);
        w_sign_b   = r_sign_b ^ r_sub;
        w_eff_sub  = r_sign_a ^ w_sign_b;
        w_exp_a    = eff_exp(r_expf_a);
        w_exp_b    = eff_exp(r_expf_b);
        w_a_ge     = {w_exp_a, r_sig_a} >= {w_exp_b, r_sig_b};
        w_big       = w_a_ge ? r_sig_a : r_sig_b;
        w_small_raw = w_a_ge ? r_sig_b : r_sig_a;
        w_exp_big   = w_a_ge ? w_exp_a : w_exp_b;
        w_sign_big  = w_a_ge ? r_sign_a : w_sign_b;
        w_diff      = w_a_ge ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
        w_shamt     = (w_diff >= XE_W'(SIG_W)) ? SH_W'(SIG_W) : w_diff[SH_W-1:0];
        w_shifted   = w_small_raw >> w_shamt;
        w_lost      = |(w_small_raw & ~({SIG_W{1'b1}} << w_shamt));
        w_small_al  = {w_shifted[SIG_W-1:1], w_shifted[0] | w_lost};

        w_special = 1'b1;
        w_sp_inv  = 1'b0;
        w_sp_res  = '0;
        if (w_a_nan || w_b_nan) begin
            w_sp_res = QNAN;
            w_sp_inv = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            w_sp_res = w_eff_sub ? QNAN : {r_sign_a, EXP_ONES, {MAN_W{1'b0}}};
            w_sp_inv = w_eff_sub;
        end else if (w_a_inf) begin
            w_sp_res = {r_sign_a, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_sp_res = {w_sign_b, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            // Like-signed zeros keep their sign; opposite signs give +0 except toward -inf.
            w_sp_res = {(r_sign_a == w_sign_b) ? r_sign_a : (r_rnd == RDN), {(W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_sp_res = {w_sign_b, r_expf_b, r_sig_b[SIG_W-2:3]};
        end else if (w_b_zero) begin
            w_sp_res = {r_sign_a, r_expf_a, r_sig_a[SIG_W-2:3]};
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- ADDSUB: magnitudes are pre-ordered, so subtraction never goes negative
    logic [SIG_W:0] w_sum;
    assign w_sum = r_eff_sub ? ({1'b0, r_big} - {1'b0, r_small})
                             : ({1'b0, r_big} + {1'b0, r_small});

    // ---------------- NORM
    logic [SH_W-1:0]  w_lzc, w_sh;
    logic [XE_W-1:0]  w_sh_lim, w_nexp;
    logic [SIG_W-1:0] w_nsig;

    always_comb begin
        w_lzc    = lzc(r_sum[SIG_W-1:0]);
        w_sh_lim = r_exp - XE_W'(1);
        w_sh     = (XE_W'(w_lzc) > w_sh_lim) ? w_sh_lim[SH_W-1:0] : w_lzc;
        if (r_sum[SIG_W]) begin
            w_nsig = {r_sum[SIG_W:2], r_sum[1] | r_sum[0]};
            w_nexp = r_exp + XE_W'(1);
        end else begin
            w_nsig = r_sum[SIG_W-1:0] << w_sh;
            w_nexp = r_exp - XE_W'(w_sh);
        end
    end

    // ---------------- ROUND
    logic             w_tiny, w_inexact, w_up, w_rcarry, w_hidden, w_ovf;
    logic [MAN_W+1:0] w_rounded;
    logic [MAN_W-1:0] w_frac;
    logic [XE_W-1:0]  w_exp_r;
    logic [W-1:0]     w_res, w_inf, w_maxf;
    logic             w_f_inv, w_f_ovf, w_f_unf, w_f_inx;

    always_comb begin
        w_tiny    = !r_nsig[SIG_W-1];
        w_inexact = r_nsig[2] | r_nsig[1] | r_nsig[0];
        case (r_rnd)
            RNE:     w_up = r_nsig[2] & (r_nsig[1] | r_nsig[0] | r_nsig[3]);
            RTZ:     w_up = 1'b0;
            RUP:     w_up = w_inexact & !r_sign;
            default: w_up = w_inexact & r_sign;
        endcase
        w_rounded = {1'b0, r_nsig[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
        w_rcarry  = w_rounded[MAN_W+1];
        w_frac    = w_rcarry ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
        w_hidden  = w_rcarry | w_rounded[MAN_W];
        w_exp_r   = r_exp + XE_W'(w_rcarry);
        w_ovf     = w_exp_r >= {2'b00, EXP_ONES};
        w_inf     = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
        w_maxf    = {r_sign, EXP_MAX, {MAN_W{1'b1}}};

        w_res   = {r_sign, w_hidden ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, w_frac};
        w_f_inv = 1'b0;
        w_f_ovf = 1'b0;
        w_f_unf = SUBNORM_EN & w_tiny & w_inexact;
        w_f_inx = w_inexact;
        if (r_bypass) begin
            w_res   = r_sp_res;
            w_f_inv = r_sp_inv;
            w_f_unf = 1'b0;
            w_f_inx = 1'b0;
        end else if (r_nzero) begin
            w_res   = {r_rnd == RDN, {(W-1){1'b0}}};
            w_f_unf = 1'b0;
            w_f_inx = 1'b0;
        end else if (w_tiny && !SUBNORM_EN) begin
            w_res   = {r_sign, {(W-1){1'b0}}};
            w_f_inx = 1'b1;
        end else if (w_ovf) begin
            case (r_rnd)
                RNE:     w_res = w_inf;
                RTZ:     w_res = w_maxf;
                RUP:     w_res = r_sign ? w_maxf : w_inf;
                default: w_res = r_sign ? w_inf : w_maxf;
            endcase
            w_f_ovf = 1'b1;
            w_f_inx = 1'b1;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before they are consumed.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (bus.in_valid) begin
                r_sign_a <= bus.input_a[W-1];
                r_expf_a <= bus.input_a[W-2:MAN_W];
                r_sig_a  <= unpack_sig(bus.input_a);
                r_sign_b <= bus.input_b[W-1];
                r_expf_b <= bus.input_b[W-2:MAN_W];
                r_sig_b  <= unpack_sig(bus.input_b);
                r_sub    <= bus.sub;
                r_rnd    <= rnd_t'(bus.rnd_mode);
            end
            S_ALIGN: begin
                r_big     <= w_big;
                r_small   <= w_small_al;
                r_exp     <= w_exp_big;
                r_sign    <= w_sign_big;
                r_eff_sub <= w_eff_sub;
                r_bypass  <= w_special;
                r_sp_res  <= w_sp_res;
                r_sp_inv  <= w_sp_inv;
            end
            S_ADDSUB: r_sum <= w_sum;
            S_NORM: begin
                r_nsig  <= w_nsig;
                r_exp   <= w_nexp;
                r_nzero <= (r_sum == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_c     <= '0;
            r_out_valid <= 1'b0;
            r_flag_inv  <= 1'b0;
            r_flag_ovf  <= 1'b0;
            r_flag_unf  <= 1'b0;
            r_flag_inx  <= 1'b0;
        end else if (r_state == S_ROUND) begin
            r_out_c     <= w_res;
            r_out_valid <= 1'b1;
            r_flag_inv  <= w_f_inv;
            r_flag_ovf  <= w_f_ovf;
            r_flag_unf  <= w_f_unf;
            r_flag_inx  <= w_f_inx;
        end else if (r_state == S_HOLD && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready       = (r_state == S_IDLE);
    assign bus.output_c       = r_out_c;
    assign bus.out_valid      = r_out_valid;
    assign bus.flag_invalid   = r_flag_inv;
    assign bus.flag_overflow  = r_flag_ovf;
    assign bus.flag_underflow = r_flag_unf;
    assign bus.flag_inexact   = r_flag_inx;
endmodule
